// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the serial shift sequencer.
package shift_seq_pkg;

  localparam int unsigned NBITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/shift_reg.sv
// Parallel-load bidirectional shift register; LOAD wins over SHIFT.
module shift_reg #(
  parameter int unsigned W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         SHIFT,
  input  logic         LOAD,
  input  logic         DIR,
  input  logic [W-1:0] DATA,
  input  logic         SER_IN,
  output logic [W-1:0] Q
);

  // DIR=0 moves bits toward Q[W-1] with SER_IN entering Q[0]; DIR=1 the reverse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)        Q <= '0;
    else if (LOAD)  Q <= DATA;
    else if (SHIFT) Q <= DIR ? {SER_IN, Q[W-1:1]} : {Q[W-2:0], SER_IN};
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Frame sequencer: accepts a byte, shifts it out one bit per DIV clocks while
// shifting RX_IN into the same register, then pulses DONE with the received byte.
module shift_seq_ctrl #(
  parameter int unsigned DIV   = 1,
  parameter int unsigned NBITS = shift_seq_pkg::NBITS
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [NBITS-1:0] IN_DATA,
  input  logic             MSB_FIRST,
  input  logic             RX_IN,
  output logic             SER_OUT,
  output logic             SER_VALID,
  output logic             DONE,
  output logic [NBITS-1:0] RX_DATA,
  output logic             BUSY
);
  import shift_seq_pkg::*;

  localparam int unsigned BCW      = $clog2(NBITS);
  localparam logic [7:0]  DIV_LAST = 8'(DIV - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(NBITS - 1);

  state_e           state_q, state_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [7:0]       div_cnt_q, div_cnt_d;
  logic [NBITS-1:0] data_q, data_d;
  logic             msb_q, msb_d;
  logic [NBITS-1:0] hold_q;
  logic [NBITS-1:0] sr_q;
  logic             sr_load, sr_shift;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      data_q    <= '0;
      msb_q     <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      data_q    <= data_d;
      msb_q     <= msb_d;
      if (state_q == ST_DONE) hold_q <= sr_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    data_d    = data_q;
    msb_d     = msb_q;
    sr_load   = 1'b0;
    sr_shift  = 1'b0;
    IN_READY  = 1'b0;
    unique case (state_q)
      // Accepting in DONE lets frames run back to back with no idle cycle.
      ST_IDLE, ST_DONE: begin
        IN_READY = 1'b1;
        if (IN_VALID) begin
          data_d  = IN_DATA;
          msb_d   = MSB_FIRST;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        sr_load   = 1'b1;
        bit_cnt_d = '0;
        div_cnt_d = '0;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (div_cnt_q == DIV_LAST) begin
          sr_shift  = 1'b1;
          div_cnt_d = '0;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_LAST) state_d = ST_DONE;
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  shift_reg #(.W(NBITS)) u_shift_reg (
    .CLK    (CLK),
    .RST    (RST),
    .SHIFT  (sr_shift),
    .LOAD   (sr_load),
    .DIR    (~msb_q),
    .DATA   (data_q),
    .SER_IN (RX_IN),
    .Q      (sr_q)
  );

  assign SER_OUT   = msb_q ? sr_q[NBITS-1] : sr_q[0];
  assign SER_VALID = (state_q == ST_SHIFT);
  assign DONE      = (state_q == ST_DONE);
  assign BUSY      = (state_q == ST_LOAD) || (state_q == ST_SHIFT);
  assign RX_DATA   = (state_q == ST_DONE) ? sr_q : hold_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench: two sequencers (DIV=1 and DIV=4) driven by directed and random
// frames; a per-instance monitor checks every cycle against a frame-timing model.
module tb_shift_seq_ctrl;

  typedef struct {
    logic [7:0] data;
    logic       msb;
    logic [7:0] rx;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] in_valid = '0;
  logic [1:0] msb = '0;
  logic [1:0] in_ready, rx_in, ser_out, ser_valid, done, busy;
  logic [7:0] in_data [2];
  logic [7:0] rx_data [2];
  logic [1:0] rx_mode [2];   // 0: RX_IN=0, 1: RX_IN=1, 2: loopback, 3: inverted loopback

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int g, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s inst=%0d got=%0h want=%0h at %0t", nm, g, got, want, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int D = (g == 0) ? 1 : 4;
    localparam int LAST = 8 * D + 1;

    shift_seq_ctrl #(.DIV(D)) u_dut (
      .CLK       (clk),
      .RST       (rst),
      .IN_VALID  (in_valid[g]),
      .IN_READY  (in_ready[g]),
      .IN_DATA   (in_data[g]),
      .MSB_FIRST (msb[g]),
      .RX_IN     (rx_in[g]),
      .SER_OUT   (ser_out[g]),
      .SER_VALID (ser_valid[g]),
      .DONE      (done[g]),
      .RX_DATA   (rx_data[g]),
      .BUSY      (busy[g])
    );

    assign rx_in[g] = (rx_mode[g] == 2'd2) ? ser_out[g] :
                      (rx_mode[g] == 2'd3) ? ~ser_out[g] : rx_mode[g][0];

    // t counts cycles since the accept cycle: 1 = load, 2..LAST = bits, LAST+1 = done.
    initial begin : mon
      int t;
      bit act;
      frame_t q[$];
      frame_t f;
      logic [7:0] hold;
      int idx;
      logic eb, esv, ed;
      act = 0; t = 0; hold = '0;
      forever begin
        @(negedge clk);
        if (rst) begin
          act = 0; t = 0; hold = '0; q.delete();
          chk("rst_busy", g, 32'(busy[g]), 32'd0);
          chk("rst_ser_valid", g, 32'(ser_valid[g]), 32'd0);
          chk("rst_done", g, 32'(done[g]), 32'd0);
          chk("rst_rx_data", g, 32'(rx_data[g]), 32'd0);
        end else begin
          if (act) t++;
          eb  = act && (t >= 1) && (t <= LAST);
          esv = act && (t >= 2) && (t <= LAST);
          ed  = act && (t == LAST + 1);
          chk("busy", g, 32'(busy[g]), 32'(eb));
          chk("in_ready", g, 32'(in_ready[g]), 32'(!eb));
          chk("ser_valid", g, 32'(ser_valid[g]), 32'(esv));
          chk("done", g, 32'(done[g]), 32'(ed));
          if ((esv || ed) && q.size() == 0) begin
            chk("frame_queue_empty", g, 32'd0, 32'd1);
          end else if (esv) begin
            f = q[0];
            idx = (t - 2) / D;
            chk("ser_out", g, 32'(ser_out[g]), 32'(f.msb ? f.data[7 - idx] : f.data[idx]));
          end else if (ed) begin
            f = q.pop_front();
            hold = f.rx;
            act = 0;
          end
          chk(ed ? "rx_data_done" : "rx_data_hold", g, 32'(rx_data[g]), 32'(hold));
          if (in_valid[g] && in_ready[g]) begin
            f.data = in_data[g];
            f.msb  = msb[g];
            case (rx_mode[g])
              2'd0:    f.rx = 8'h00;
              2'd1:    f.rx = 8'hFF;
              2'd2:    f.rx = in_data[g];
              default: f.rx = ~in_data[g];
            endcase
            q.push_back(f);
            act = 1;
            t = 0;
          end
        end
      end
    end
  end

  // Presents one byte; returns one step after the accepting edge. keep leaves
  // IN_VALID high so the next call can be accepted in the DONE cycle.
  task automatic send(input int g, input logic [7:0] d, input logic m,
                      input logic [1:0] mode, input logic keep);
    int n;
    n = 0;
    if (mode != rx_mode[g]) begin
      while (busy[g] && n < 5000) begin @(posedge clk); #1; n++; end
      chk("idle_timeout", g, 32'(busy[g]), 32'd0);
      rx_mode[g] = mode;
    end
    in_data[g] = d; msb[g] = m; in_valid[g] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ready[g] && n < 5000);
    if (!in_ready[g]) chk("accept_timeout", g, 32'(in_ready[g]), 32'd1);
    @(posedge clk); #1;
    if (!keep) begin
      in_valid[g] = 1'b0;
      in_data[g] = 8'($urandom);
      msb[g] = 1'($urandom_range(1));
    end
  endtask

  // Offer a stray byte while a frame is in flight; it must be ignored.
  task automatic pulse(input int g);
    in_valid[g] = 1'b1; in_data[g] = 8'hFF; msb[g] = ~msb[g];
    repeat (2) begin @(posedge clk); #1; end
    in_valid[g] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic run_random(input int g, input int n);
    logic [1:0] mode, nmode;
    logic keep;
    mode = 2'($urandom_range(3));
    for (int i = 0; i < n; i++) begin
      nmode = ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : mode;
      keep = (i < n - 1) && (nmode == mode) && ($urandom_range(1) == 1);
      send(g, 8'($urandom), 1'($urandom_range(1)), mode, keep);
      if (!keep) begin
        if ($urandom_range(3) == 0) pulse(g);
        idle($urandom_range(2));
      end
      mode = nmode;
    end
  endtask

  initial begin
    rx_mode[0] = 2'd0; rx_mode[1] = 2'd0;
    in_data[0] = '0; in_data[1] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    send(0, 8'hA5, 1'b1, 2'd2, 1'b0); idle(14);
    send(0, 8'h01, 1'b0, 2'd1, 1'b0); idle(14);
    send(0, 8'h5A, 1'b1, 2'd2, 1'b1);
    send(0, 8'hC3, 1'b1, 2'd2, 1'b0); idle(14);
    send(0, 8'h96, 1'b0, 2'd3, 1'b0); pulse(0); idle(14);

    // Reset while bit 3 is on the line: outputs must drop before any clock edge.
    send(0, 8'h66, 1'b1, 2'd2, 1'b0);
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_busy", 0, 32'(busy[0]), 32'd0);
    chk("async_ser_valid", 0, 32'(ser_valid[0]), 32'd0);
    chk("async_done", 0, 32'(done[0]), 32'd0);
    chk("async_rx_data", 0, 32'(rx_data[0]), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    chk("post_rst_ready", 0, 32'(in_ready[0]), 32'd1);
    send(0, 8'h81, 1'b1, 2'd2, 1'b0); idle(14);
    send(0, 8'h81, 1'b0, 2'd0, 1'b0); idle(14);

    run_random(0, 25);
    idle(14);

    send(1, 8'h3C, 1'b1, 2'd2, 1'b0); pulse(1); idle(40);
    send(1, 8'hC5, 1'b0, 2'd3, 1'b0); idle(40);
    run_random(1, 12);
    idle(60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 Parameter: DIV, 1, clock cycles per serial bit (legal 1..255).
REQ-002 Parameter: NBITS, 8, frame length in bits (fixed at 8 for this block).
REQ-003 CLK  input  1  single clock; all state changes on rising edge.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 IN_VALID  input  1  byte offered for transfer.
REQ-006 IN_READY  output  1  controller can accept a byte this cycle.
REQ-007 IN_DATA  input  8  byte to transmit.
REQ-008 MSB_FIRST  input  1  bit order, sampled only at accept (1 = Q[7] first).
REQ-009 RX_IN  input  1  serial receive bit, shifted in alongside each transmit bit.
REQ-010 SER_OUT  output  1  current transmit bit.
REQ-011 SER_VALID  output  1  SER_OUT is a frame bit.
REQ-012 DONE  output  1  one-cycle pulse at frame end.
REQ-013 RX_DATA  output  8  received byte.
REQ-014 BUSY  output  1  frame in progress (LOAD or SHIFT state).

Function
REQ-015 The FSM SHALL have states IDLE, LOAD, SHIFT, DONE.
REQ-016 IN_READY SHALL be 1 in IDLE and DONE, 0 otherwise; accept = IN_VALID & IN_READY.
REQ-017 On accept, the FSM SHALL latch IN_DATA and MSB_FIRST and enter LOAD next cycle. Without accept, DONE SHALL return to IDLE.
REQ-018 LOAD SHALL last 1 cycle, drive the shift_reg LOAD=1 with DATA=latched byte, then enter SHIFT with bit_cnt=0 and div_cnt=0.
REQ-019 In SHIFT, div_cnt SHALL count 0..DIV-1. The shift_reg SHIFT SHALL be 1 only when div_cnt==DIV-1, which advances bit_cnt and wraps div_cnt to 0.
REQ-020 When the shift with bit_cnt==7 occurs, the FSM SHALL enter DONE for exactly 1 cycle.
REQ-021 The shift_reg DIR SHALL be 0 (shift toward Q[7], SER_IN enters Q[0]) when latched MSB_FIRST=1, else 1 (toward Q[0], SER_IN enters Q[7]). SER_IN SHALL be RX_IN.
REQ-022 SER_OUT SHALL be Q[7] when MSB_FIRST latched 1, else Q[0]. SER_VALID SHALL be 1 exactly in SHIFT, so each bit is held DIV cycles.
REQ-023 Latency: DONE SHALL assert 8*DIV+2 cycles after the accept edge. Back-to-back frame period SHALL be 8*DIV+2 cycles (accept in DONE, no IDLE gap).
REQ-024 RX_DATA SHALL equal Q during DONE. A hold register SHALL capture Q at the end of DONE and drive RX_DATA at all other times.
REQ-025 IN_VALID during LOAD/SHIFT SHALL be ignored, and IN_DATA/MSB_FIRST changes SHALL not affect the frame in progress.
REQ-026 LOAD and SHIFT to the shift_reg SHALL never be asserted in the same cycle, and neither SHALL be asserted in IDLE/DONE.

Reset
REQ-027 RST=1 SHALL immediately force IDLE, with counters 0, shift_reg Q=0, RX_DATA hold=0, SER_VALID=0, DONE=0, BUSY=0, and IN_READY=1 after release.
REQ-028 Reset mid-frame SHALL abort the frame without a DONE pulse. The first accept after release SHALL run a complete, correct frame.

Structure
REQ-029 Package shift_seq_pkg SHALL hold the state enum typedef and NBITS constant.
REQ-030 The existing shift_reg (CLK, RST, SHIFT, LOAD, DIR, DATA, SER_IN, Q; LOAD priority over SHIFT) SHALL be instantiated as the sole sub-module. The FSM, counters and RX hold register SHALL be in shift_seq_ctrl.

Verification
REQ-031 DIV=1, MSB_FIRST=1, IN_DATA=8'hA5, RX_IN=SER_OUT loopback -> SER_OUT 1,0,1,0,0,1,0,1; DONE at accept+10; RX_DATA=8'hA5.
REQ-032 DIV=1, MSB_FIRST=0, IN_DATA=8'h01, RX_IN=1 -> SER_OUT 1,0,0,0,0,0,0,0; RX_DATA=8'hFF, held after DONE.
REQ-033 DIV=4, IN_DATA=8'h3C -> each bit stable 4 cycles, SHIFT pulses every 4th cycle, DONE at accept+34.
REQ-034 IN_VALID held high with 8'h5A then 8'hC3 -> second accept in the DONE cycle, LOAD next cycle, frame period 10 cycles at DIV=1.
REQ-035 RST asserted during bit 3 -> SER_VALID/BUSY drop without waiting for a clock, no DONE; the next frame with 8'h81 transfers correctly.
REQ-036 IN_VALID pulsed with 8'hFF during SHIFT -> ignored; the current frame is unchanged and IN_READY stays 0.
